mips_load_store_unit: RTL and testbench
=======================================

MIPS_LOAD_STORE_UNIT -- requirements
Module: mips_load_store_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-003 req_valid  input  1  core presents a load/store request.
REQ-004 req_ready  output  1  LSU can accept a request this cycle.
REQ-005 req_write  input  1  1=store, 0=load.
REQ-006 req_size  input  3  MIPS opcode[2:0]: 000 byte, 001 half, 011 word, 100 byte-unsigned, 101 half-unsigned; other codes illegal.
REQ-007 req_address  input  32  byte address, already computed by the core ALU.
REQ-008 req_writedata  input  32  store data; the value is taken from its low bits.
REQ-009 resp_valid  output  1  one-cycle pulse: the request has completed.
REQ-010 resp_readdata  output  32  load result, extended; 0 for stores and errors.
REQ-011 resp_error  output  1  qualifies resp_valid: misaligned access or illegal size.
REQ-012 data_address  output  32  word-aligned memory address: req_address with bits [1:0] forced to 00.
REQ-013 data_read / data_write  output  1 each  memory strobes; never both high.
REQ-014 data_byteenable  output  4  byte-lane enables; lane k = bits 8k+7:8k.
REQ-015 data_writedata  output  32  store data placed on the addressed lanes.
REQ-016 data_readdata  input  32  combinational read data; valid when waitrequest=0.
REQ-017 data_waitrequest  input  1  memory stall; strobes and address must be held while it is high.

Function
REQ-018 FSM states are IDLE, ACCESS and RESP; req_ready=1 only in IDLE.
REQ-019 IDLE, req_valid=1: address, size, write flag and write data are latched; the FSM goes to ACCESS, or straight to RESP with the error flag set if the request is misaligned or illegal.
REQ-020 Misalignment rules: half with address[0]=1; word with address[1:0]!=00; illegal size codes are errors. No memory strobe is raised for an error.
REQ-021 ACCESS: data_read or data_write is driven from the latched request. The FSM stays in ACCESS while data_waitrequest=1, with all data_* outputs stable.
REQ-022 ACCESS with waitrequest=0: a load captures data_readdata that same cycle; the FSM goes to RESP. Minimum request-to-response latency is 2 cycles (accept, ACCESS, then RESP pulse).
REQ-023 RESP: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE. A new request is accepted no earlier than the cycle after RESP.
REQ-024 Byte enables are little-endian:
  - byte: 1<<addr[1:0]
  - half: 0011 if addr[1]=0, else 1100
  - word: 1111
REQ-025 Store lane placement:
  - byte: writedata[7:0] is replicated to all 4 lanes.
  - half: writedata[15:0] is replicated to both halves.
  - Only the enabled lanes are meaningful.
REQ-026 Load extraction: the addressed byte or half is shifted to bit 0; sizes 000 and 001 are sign-extended, 100 and 101 zero-extended, 011 is passed through unchanged.
REQ-027 Outside ACCESS: data_read=data_write=0 and data_byteenable=0000. The resp_* outputs are 0 whenever resp_valid=0.
REQ-028 A change of req_* inputs after acceptance has no effect on the transaction in flight.

Reset
REQ-029 On reset=0, regardless of clk:
  - FSM goes to IDLE.
  - req_ready=1.
  - resp_valid=0, resp_error=0, resp_readdata=0.
  - data_read=0, data_write=0, data_byteenable=0000, data_address=0, data_writedata=0.
REQ-030 Reset asserted during ACCESS drops the strobes immediately and abandons the transaction; no resp_valid pulse is issued for it.
REQ-031 After reset deassertion, the first rising edge with req_valid=1 is accepted.

Verification
REQ-032 LW, address 0x100, readdata=0x8899AABB, no wait: data_read=1 with byteenable 1111 in cycle 1; resp_valid=1 with resp_readdata=0x8899AABB in cycle 2.
REQ-033 Byte loads at address 0x103, readdata=0x80112233: LB gives 0xFFFFFF80; LBU gives 0x00000080; byteenable=1000 in both cases.
REQ-034 SH, address 0x22, writedata=0x0000BEEF, waitrequest held high for 3 cycles:
  - data_write=1, byteenable=1100, data_writedata[31:16]=0xBEEF, data_address=0x20, all stable for 4 cycles.
  - Then a single resp_valid with resp_readdata=0.
REQ-035 LW at address 0x102: resp_error=1 and resp_valid=1 on the cycle after acceptance; data_read never asserts.
REQ-036 Reset=0 asserted in the 2nd waitrequest cycle of a load: strobes drop to 0 before the next edge; no resp_valid; req_ready=1 after release.
REQ-037 Back-to-back: SB then LBU to the same address 0x40, modelled memory, writedata=0x000000A5: LBU returns 0x000000A5; req_ready is low from acceptance through RESP for each request.

Source files
------------

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: it accepts one core request and runs it as a single memory access
// with wait states, then returns the extended load data or an error on a one-cycle response.
module mips_load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_address,
    input  logic [31:0] req_writedata,
    output logic        resp_valid,
    output logic [31:0] resp_readdata,
    output logic        resp_error,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        write_q;
    logic        err_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_d;

    function automatic logic size_error(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'b000, 3'b100: size_error = 1'b0;
            3'b001, 3'b101: size_error = a[0];
            3'b011:         size_error = (a != 2'b00);
            default:        size_error = 1'b1;
        endcase
    endfunction

    // Store data is replicated across lanes at accept time; only the enabled lanes matter.
    function automatic logic [31:0] place_store(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'b000, 3'b100: place_store = {4{wd[7:0]}};
            3'b001, 3'b101: place_store = {2{wd[15:0]}};
            default:        place_store = wd;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] sz, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rd >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            3'b000:  extract_load = {{24{b[7]}}, b};
            3'b100:  extract_load = {24'h0, b};
            3'b001:  extract_load = {{16{h[15]}}, h};
            3'b101:  extract_load = {16'h0, h};
            default: extract_load = rd;
        endcase
    endfunction

    always_comb begin
        be_d = '0;
        case (size_q)
            3'b000, 3'b100: be_d = 4'b0001 << addr_q[1:0];
            3'b001, 3'b101: be_d = addr_q[1] ? 4'b1100 : 4'b0011;
            3'b011:         be_d = 4'b1111;
            default:        be_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        addr_q  <= req_address;
                        wdata_q <= place_store(req_size, req_writedata);
                        rdata_q <= '0;
                        err_q   <= size_error(req_size, req_address[1:0]);
                        state_q <= size_error(req_size, req_address[1:0]) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!data_waitrequest) begin
                        if (!write_q) begin
                            rdata_q <= extract_load(size_q, addr_q[1:0], data_readdata);
                        end
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode straight from registered state, so reset drops them at once.
    assign req_ready       = (state_q == IDLE);
    assign data_address    = {addr_q[31:2], 2'b00};
    assign data_read       = (state_q == ACCESS) && !write_q;
    assign data_write      = (state_q == ACCESS) && write_q;
    assign data_byteenable = (state_q == ACCESS) ? be_d : 4'b0000;
    assign data_writedata  = wdata_q;
    assign resp_valid      = (state_q == RESP);
    assign resp_error      = resp_valid && err_q;
    assign resp_readdata   = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit: a vector table over a word-array memory model,
// plus hand-written sequences for wait states, reset mid-access and back-to-back requests.
module tb_mips_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_address;
    logic [31:0] req_writedata;
    logic        resp_valid;
    logic [31:0] resp_readdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        data_waitrequest;

    logic [31:0] mem [0:255];
    int          n_chk;
    int          n_fail;
    int          viol;

    mips_load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_address      (req_address),
        .req_writedata    (req_writedata),
        .resp_valid       (resp_valid),
        .resp_readdata    (resp_readdata),
        .resp_error       (resp_error),
        .data_address     (data_address),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_byteenable  (data_byteenable),
        .data_writedata   (data_writedata),
        .data_readdata    (data_readdata),
        .data_waitrequest (data_waitrequest)
    );

    assign data_readdata = mem[data_address[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Interface invariants that must hold on every cycle.
    initial viol = 0;
    always @(negedge clk) begin
        if (!resp_valid && (resp_readdata != 32'h0 || resp_error)) viol++;
        if (data_read && data_write) viol++;
        if (!(data_read || data_write) && data_byteenable != 4'b0000) viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int waits,
                           output logic [31:0] rd, output logic er, output logic [3:0] be,
                           output logic [31:0] adr, output logic [31:0] wdo, output int lat,
                           output int nstb, output int unstable, output int rdy_bad,
                           output logic got);
        int          wl;
        logic [69:0] snap;
        rd = '0; er = 1'b0; be = '0; adr = '0; wdo = '0;
        lat = 0; nstb = 0; unstable = 0; rdy_bad = 0; got = 1'b0; wl = waits; snap = '0;
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_address = a; req_writedata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_size = 3'b011;
        req_address = $urandom; req_writedata = $urandom;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (req_ready) rdy_bad++;
            if (data_read || data_write) begin
                if (nstb == 0) begin
                    snap = {data_address, data_writedata, data_byteenable, data_read, data_write};
                    be = data_byteenable; adr = data_address; wdo = data_writedata;
                end else if (snap !== {data_address, data_writedata, data_byteenable,
                                       data_read, data_write}) begin
                    unstable++;
                end
                nstb++;
                if (wl > 0) begin
                    data_waitrequest = 1'b1;
                    wl--;
                end else begin
                    data_waitrequest = 1'b0;
                    if (data_write) begin
                        for (int k = 0; k < 4; k++)
                            if (data_byteenable[k])
                                mem[data_address[9:2]][8*k +: 8] = data_writedata[8*k +: 8];
                    end
                end
            end else begin
                data_waitrequest = 1'b0;
            end
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_readdata;
                er  = resp_error;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] pre;
        int          waits;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] rd, adr, wdo;
        logic        er, got;
        logic [3:0]  be;
        int          lat, nstb, unstable, rdy_bad, pulses;

        n_chk = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        vecs[0]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h8899AABB, 0, 32'h8899AABB, 1'b0, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 1'b0, 4'h8, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1, 32'h00000080, 1'b0, 4'h8, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80112233, 0, 32'hFFFF8011, 1'b0, 4'hC, 32'h0};
        vecs[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h80112233, 0, 32'h00002233, 1'b0, 4'h3, 32'h0};
        vecs[5]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h80112233, 2, 32'h00000022, 1'b0, 4'h2, 32'h0};
        vecs[6]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h0000F00D, 0, 32'hFFFFF00D, 1'b0, 4'h3, 32'h0};
        vecs[7]  = '{1'b0, 3'b011, 32'h104, 32'h0,        32'h7FFFFFFF, 2, 32'h7FFFFFFF, 1'b0, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, 3'b011, 32'h102, 32'h0,        32'h11111111, 0, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 3'b101, 32'h101, 32'h0,        32'h11111111, 0, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h11111111, 0, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 3'b111, 32'h108, 32'hFFFFFFFF, 32'h55555555, 0, 32'h0,        1'b1, 4'h0, 32'h55555555};
        vecs[12] = '{1'b1, 3'b011, 32'h10C, 32'h12345678, 32'h0,        1, 32'h0,        1'b0, 4'hF, 32'h12345678};
        vecs[13] = '{1'b1, 3'b000, 32'h111, 32'hFFFFFFAB, 32'h11223344, 0, 32'h0,        1'b0, 4'h2, 32'h1122AB44};
        vecs[14] = '{1'b1, 3'b001, 32'h112, 32'h9876CAFE, 32'h11223344, 0, 32'h0,        1'b0, 4'hC, 32'hCAFE3344};

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 3'b000;
        req_address = '0; req_writedata = '0; data_waitrequest = 1'b0;
        #3;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
        chk("rst_resp_rdata", resp_readdata, 32'h0);
        chk("rst_strobes",    {30'h0, data_read, data_write}, 32'h0);
        chk("rst_be",         {28'h0, data_byteenable}, 32'h0);
        chk("rst_address",    data_address, 32'h0);
        chk("rst_wdata",      data_writedata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            mem[vecs[i].a[9:2]] = vecs[i].pre;
            run_req(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].waits,
                    rd, er, be, adr, wdo, lat, nstb, unstable, rdy_bad, got);
            chk($sformatf("v%0d_got_resp", i), {31'h0, got}, 32'h1);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_error", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_be", i), {28'h0, be}, {28'h0, vecs[i].exp_be});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_err ? 1 : 2 + vecs[i].waits);
            chk($sformatf("v%0d_strobe_cycles", i), nstb, vecs[i].exp_err ? 0 : 1 + vecs[i].waits);
            chk($sformatf("v%0d_stable", i), unstable, 0);
            chk($sformatf("v%0d_ready_low", i), rdy_bad, 0);
            if (!vecs[i].exp_err)
                chk($sformatf("v%0d_address", i), adr, {vecs[i].a[31:2], 2'b00});
            if (vecs[i].w)
                chk($sformatf("v%0d_mem", i), mem[vecs[i].a[9:2]], vecs[i].exp_mem);
        end

        // SH to 0x22 with three wait cycles.
        mem[8] = 32'h0;
        run_req(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 3,
                rd, er, be, adr, wdo, lat, nstb, unstable, rdy_bad, got);
        chk("sh_got_resp", {31'h0, got}, 32'h1);
        chk("sh_be", {28'h0, be}, 32'hC);
        chk("sh_wdata_hi", {16'h0, wdo[31:16]}, 32'hBEEF);
        chk("sh_address", adr, 32'h20);
        chk("sh_strobe_cycles", nstb, 4);
        chk("sh_stable", unstable, 0);
        chk("sh_rdata", rd, 32'h0);
        chk("sh_error", {31'h0, er}, 32'h0);
        chk("sh_mem", mem[8], 32'hBEEF0000);
        @(negedge clk);
        chk("sh_single_pulse", {31'h0, resp_valid}, 32'h0);

        // Reset during the second wait cycle of a load abandons it.
        mem[8'h40] = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'b011; req_address = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstacc_read_on", {31'h0, data_read}, 32'h1);
        data_waitrequest = 1'b1;
        @(negedge clk);
        data_waitrequest = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rstacc_read_drop", {31'h0, data_read}, 32'h0);
        chk("rstacc_be_drop", {28'h0, data_byteenable}, 32'h0);
        chk("rstacc_ready", {31'h0, req_ready}, 32'h1);
        chk("rstacc_address", data_address, 32'h0);
        @(negedge clk);
        data_waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("rstacc_no_resp", pulses, 0);
        chk("rstacc_ready_after", {31'h0, req_ready}, 32'h1);

        // Back-to-back SB then LBU at 0x40.
        mem[16] = 32'h5A5A5A00;
        run_req(1'b1, 3'b000, 32'h40, 32'h000000A5, 0,
                rd, er, be, adr, wdo, lat, nstb, unstable, rdy_bad, got);
        chk("b2b_sb_got", {31'h0, got}, 32'h1);
        chk("b2b_sb_be", {28'h0, be}, 32'h1);
        chk("b2b_sb_ready_low", rdy_bad, 0);
        run_req(1'b0, 3'b100, 32'h40, 32'h0, 0,
                rd, er, be, adr, wdo, lat, nstb, unstable, rdy_bad, got);
        chk("b2b_lbu_got", {31'h0, got}, 32'h1);
        chk("b2b_lbu_rdata", rd, 32'h000000A5);
        chk("b2b_lbu_ready_low", rdy_bad, 0);
        chk("b2b_lbu_latency", lat, 2);

        @(negedge clk);
        chk("invariants", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
